router_pkt_tx: RTL
==================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter: GAP_CYCLES, 3, idle cycles after parity byte before next request (legal >=3).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clock input 1 (all logic on rising edge); resetn input 1 (asynchronous, active-low).
REQ-003 SHALL have port: req_valid input 1, packet request.
REQ-004 SHALL have port: req_addr input 2, destination address.
REQ-005 SHALL have port: req_len input 6, payload length in bytes.
REQ-006 SHALL have port: req_inj_err input 1, invert parity byte of this packet.
REQ-007 SHALL have port: req_ready output 1, request accepted when req_valid&&req_ready.
REQ-008 SHALL have port: pl_valid input 1, payload byte valid.
REQ-009 SHALL have port: pl_data input 8, payload byte.
REQ-010 SHALL have port: pl_ready output 1, payload byte accepted when pl_valid&&pl_ready.
REQ-011 SHALL have port: data_in output 8, byte to router.
REQ-012 SHALL have port: pkt_valid output 1, header/payload valid to router.
REQ-013 SHALL have port: busy input 1, router stall; byte on data_in not consumed at an edge where busy=1.
REQ-014 SHALL have port: error input 1, router parity-error indication.
REQ-015 SHALL have port: done output 1, one-cycle pulse when parity byte consumed.
REQ-016 SHALL have port: bad_req output 1, one-cycle pulse on rejected request.
REQ-017 SHALL have port: err_flag output 1, sticky router error seen for last packet.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP; all outputs registered except req_ready=(state==IDLE) and pl_ready=(state==LOAD).
REQ-019 IDLE, accepted request with req_addr==3 or req_len==0: SHALL pulse bad_req next cycle, stay IDLE, keep pkt_valid=0.
REQ-020 IDLE, accepted legal request: SHALL latch addr, len, inj_err; header={len,addr}; parity accumulator=header; clear err_flag; go LOAD.
REQ-021 LOAD: each accepted pl byte SHALL be written to internal 64x8 buffer at index cnt and XORed into parity; after byte len is accepted, SHALL go HEADER driving data_in=header, pkt_valid=1 on that same edge.
REQ-022 HEADER/PAYLOAD/PARITY: at an edge with busy=1 SHALL hold data_in, pkt_valid and state unchanged, unbounded.
REQ-023 HEADER, busy=0: SHALL drive buffer[0], cnt=1, go PAYLOAD.
REQ-024 PAYLOAD, busy=0: if cnt<len drive buffer[cnt], cnt+1; if cnt==len drive parity (XOR 0xFF when inj_err), pkt_valid=0, go PARITY.
REQ-025 PARITY, busy=0: SHALL drive data_in=0, pkt_valid=0, pulse done, go GAP.
REQ-026 GAP: SHALL count GAP_CYCLES cycles then go IDLE; error=1 sampled in PARITY or GAP SHALL set err_flag.
REQ-027 pkt_valid SHALL be high for exactly header plus len distinct bytes, contiguous except busy holds; never high outside HEADER/PAYLOAD.
REQ-028 busy and error SHALL be ignored in IDLE and LOAD; pl_valid ignored outside LOAD; req_valid ignored outside IDLE.
REQ-029 len=63 SHALL work (cnt 6 bits, no wrap before compare).

Reset
REQ-030 resetn low SHALL immediately force state=IDLE, data_in=0, pkt_valid=0, done=0, bad_req=0, err_flag=0, cnt=0, parity=0, regardless of state; buffer contents need not be reset.
REQ-031 After resetn release, a packet interrupted mid-transfer SHALL NOT resume; next request starts fresh.

Verification
REQ-032 addr=1 len=3 payload A1,B2,C3, busy=0 -> data_in 0D,A1,B2,C3 with pkt_valid=1, then DD with pkt_valid=0, done pulse, req_ready=1 after 3 GAP cycles.
REQ-033 Same packet, busy=1 for 2 edges after header appears -> 0D held 3 cycles, remaining sequence and parity DD unchanged.
REQ-034 addr=3 len=5 -> bad_req pulse, req_ready stays 1, pl_ready stays 0, pkt_valid stays 0.
REQ-035 addr=2 len=1 payload 55 inj_err=1 -> data_in 06,55 then AC; error=1 driven in GAP -> err_flag=1 until next accepted request.
REQ-036 resetn low during PAYLOAD byte 2 -> pkt_valid=0, data_in=00 without clock edge; req_ready=1 after release.
REQ-037 addr=0 len=63 -> header FC, 63 buffered bytes in order, parity = XOR of all 64 bytes.

Source files
------------

// File: rtl/router_pkt_tx_if.sv
// Handshake and byte-bus bundle between a packet source, the transmitter and the router.
interface router_pkt_tx_if;
    logic       req_valid;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       req_inj_err;
    logic       req_ready;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       busy;
    logic       error;
    logic       done;
    logic       bad_req;
    logic       err_flag;

    // Transmitter side
    modport slave (
        input  req_valid, req_addr, req_len, req_inj_err, pl_valid, pl_data, busy, error,
        output req_ready, pl_ready, data_in, pkt_valid, done, bad_req, err_flag
    );

    // Source / router side
    modport master (
        output req_valid, req_addr, req_len, req_inj_err, pl_valid, pl_data, busy, error,
        input  req_ready, pl_ready, data_in, pkt_valid, done, bad_req, err_flag
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and parity
// byte to the router, honouring the router's busy stall, then idles for a gap.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 3
) (
    input  logic           clock,
    input  logic           resetn,
    router_pkt_tx_if.slave bus
);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [5:0]    len_q, len_d;
    logic [1:0]    addr_q, addr_d;
    logic          inj_q, inj_d;
    logic [7:0]    parity_q, parity_d;
    logic [7:0]    data_q, data_d;
    logic          pv_q, pv_d;
    logic          done_q, done_d;
    logic          bad_q, bad_d;
    logic          err_q, err_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          buf_we;
    logic [7:0]    mem [64];

    assign bus.req_ready = (state_q == IDLE);
    assign bus.pl_ready  = (state_q == LOAD);
    assign bus.data_in   = data_q;
    assign bus.pkt_valid = pv_q;
    assign bus.done      = done_q;
    assign bus.bad_req   = bad_q;
    assign bus.err_flag  = err_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        addr_d   = addr_q;
        inj_d    = inj_q;
        parity_d = parity_q;
        data_d   = data_q;
        pv_d     = pv_q;
        done_d   = 1'b0;
        bad_d    = 1'b0;
        err_d    = err_q;
        gap_d    = gap_q;
        buf_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    // Address 3 has no router port; a zero-length packet is meaningless
                    if (bus.req_addr == 2'd3 || bus.req_len == 6'd0) begin
                        bad_d = 1'b1;
                    end else begin
                        addr_d   = bus.req_addr;
                        len_d    = bus.req_len;
                        inj_d    = bus.req_inj_err;
                        parity_d = {bus.req_len, bus.req_addr};
                        err_d    = 1'b0;
                        cnt_d    = 6'd0;
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.pl_valid) begin
                    buf_we   = 1'b1;
                    parity_d = parity_q ^ bus.pl_data;
                    if (cnt_q == len_q - 6'd1) begin
                        data_d  = {len_q, addr_q};
                        pv_d    = 1'b1;
                        cnt_d   = 6'd0;
                        state_d = HEADER;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            HEADER: begin
                if (!bus.busy) begin
                    data_d  = mem[0];
                    cnt_d   = 6'd1;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!bus.busy) begin
                    if (cnt_q < len_q) begin
                        data_d = mem[cnt_q];
                        cnt_d  = cnt_q + 6'd1;
                    end else begin
                        // Parity travels with pkt_valid low; inj_err corrupts it on purpose
                        data_d  = parity_q ^ {8{inj_q}};
                        pv_d    = 1'b0;
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bus.error) err_d = 1'b1;
                if (!bus.busy) begin
                    data_d  = 8'd0;
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (bus.error) err_d = 1'b1;
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
                else                               gap_d   = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            inj_q    <= 1'b0;
            parity_q <= '0;
            data_q   <= '0;
            pv_q     <= 1'b0;
            done_q   <= 1'b0;
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            inj_q    <= inj_d;
            parity_q <= parity_d;
            data_q   <= data_d;
            pv_q     <= pv_d;
            done_q   <= done_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            gap_q    <= gap_d;
        end
    end

    // Payload buffer; contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (buf_we) mem[cnt_q] <= bus.pl_data;
    end
endmodule
